// File: rtl/ats_pkg.sv
// Shared types and constants for the ATS command issuer: command record,
// control FSM states and the synthetic timeout status code.
package ats_pkg;
    localparam int CTRL_W = 16;
    localparam int DATA_W = 24;
    localparam int STAT_W = 2;
    localparam int CNT_W  = 16;

    localparam logic [STAT_W-1:0] STAT_TIMEOUT = 2'b11;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrlA;
        logic [CTRL_W-1:0] ctrlB;
    } ats_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } ats_state_e;
endpackage

// File: rtl/ats_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one wrap bit so full and empty
// can be told apart without a separate occupancy counter.
module ats_cmd_fifo
    import ats_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  ats_cmd_t push_data,
    input  logic     pop,
    output ats_cmd_t head,
    output logic     full,
    output logic     empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    ats_cmd_t    mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/ats_cmd_issuer.sv
// Queues commands, issues them one at a time to the ATS stage, and holds
// each completion (or a synthetic timeout) until downstream accepts it.
module ats_cmd_issuer
    import ats_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CTRL_W-1:0] cmd_ctrlA,
    input  logic [CTRL_W-1:0] cmd_ctrlB,
    output logic              ats_req,
    output logic [CTRL_W-1:0] ats_ctrlA,
    output logic [CTRL_W-1:0] ats_ctrlB,
    input  logic              ats_ready,
    input  logic [STAT_W-1:0] ats_stat,
    input  logic [DATA_W-1:0] ats_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [STAT_W-1:0] rsp_stat,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);
    // Counter compares against TIMEOUT-1 so the abort lands on the
    // TIMEOUT-th WAIT cycle without ats_ready.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    ats_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic           rdy_q;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    ats_cmd_t       head;
    ats_cmd_t       in_cmd;

    assign in_cmd    = '{ctrlA: cmd_ctrlA, ctrlB: cmd_ctrlB};
    assign cmd_ready = rdy_q && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = (state != IDLE) || !empty;

    ats_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_cmd),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rdy_q     <= 1'b0;
            ats_req   <= 1'b0;
            ats_ctrlA <= '0;
            ats_ctrlB <= '0;
            rsp_valid <= 1'b0;
            rsp_stat  <= '0;
            rsp_data  <= '0;
        end else begin
            rdy_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        ats_ctrlA <= head.ctrlA;
                        ats_ctrlB <= head.ctrlB;
                        ats_req   <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ats_req <= 1'b0;
                    cnt     <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // A completion on the abort cycle still carries real data.
                    if (ats_ready) begin
                        rsp_stat  <= ats_stat;
                        rsp_data  <= ats_data;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_stat  <= STAT_TIMEOUT;
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ats_cmd_issuer.sv
// Directed bench for ats_cmd_issuer: a vector table of single transactions
// plus hand sequences for backpressure, FIFO fill and mid-flight reset.
module tb_ats_cmd_issuer;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_ctrlA, cmd_ctrlB;
    logic        ats_req;
    logic [15:0] ats_ctrlA, ats_ctrlB;
    logic        ats_ready;
    logic [1:0]  ats_stat;
    logic [23:0] ats_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_stat;
    logic [23:0] rsp_data;
    logic        busy;

    ats_cmd_issuer #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ctrlA(cmd_ctrlA), .cmd_ctrlB(cmd_ctrlB),
        .ats_req(ats_req), .ats_ctrlA(ats_ctrlA), .ats_ctrlB(ats_ctrlB),
        .ats_ready(ats_ready), .ats_stat(ats_stat), .ats_data(ats_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_stat(rsp_stat), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_req = -1;
    int t, t_resp;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    typedef struct {
        logic [15:0] a, b;
        int          d;     // cycles after ats_req that ats_ready pulses; 0 = never
        logic [1:0]  st;
        logic [23:0] dat;
        logic [1:0]  est;
        logic [23:0] edat;
        int          lat;   // cycles from ats_req to first rsp_valid
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        t++;
        if (rsp_valid && t_resp < 0) t_resp = t;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        cmd_valid = 1'b1; cmd_ctrlA = a; cmd_ctrlB = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req(output int k);
        k = 0;
        while (!ats_req && k < 30) begin tick(); k++; end
    endtask

    task automatic wait_rsp(output int k);
        k = 0;
        while (!rsp_valid && k < 30) begin tick(); k++; end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Issue monitor: records every ats_req pulse and checks pulse spacing.
    always @(negedge clk) begin
        if (!reset) last_req = -1;
        else if (ats_req) begin
            qa.push_back(ats_ctrlA);
            qb.push_back(ats_ctrlB);
            if (last_req >= 0) begin
                n_tests++;
                if (cyc - last_req < 4) begin
                    n_fail++;
                    $display("FAIL req_gap: got %0d cycles expected >= 4", cyc - last_req);
                end
            end
            last_req = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, cd, qsz, seen;
        vecs[0] = '{16'h1234, 16'hABCD, 3, 2'b01, 24'hC0FFEE, 2'b01, 24'hC0FFEE, 4};
        vecs[1] = '{16'h0001, 16'hFFFF, 0, 2'b00, 24'h000000, 2'b11, 24'h000000, 9};
        vecs[2] = '{16'h5A5A, 16'hA5A5, 8, 2'b10, 24'h000055, 2'b10, 24'h000055, 9};
        vecs[3] = '{16'h0F0F, 16'hF0F0, 9, 2'b01, 24'h123456, 2'b11, 24'h000000, 9};
        vecs[4] = '{16'hFFFF, 16'h0000, 1, 2'b00, 24'hFFFFFF, 2'b00, 24'hFFFFFF, 2};
        vecs[5] = '{16'h8000, 16'h0001, 7, 2'b11, 24'hABCDEF, 2'b11, 24'hABCDEF, 8};

        reset = 1'b0; cmd_valid = 1'b0; cmd_ctrlA = '0; cmd_ctrlB = '0;
        ats_ready = 1'b0; ats_stat = '0; ats_data = '0; rsp_ready = 1'b0;
        #2;
        chk("rst_flags", {ats_req, rsp_valid, busy, cmd_ready}, 4'b0000);
        chk("rst_ctrl", {ats_ctrlA, ats_ctrlB}, 32'h0);
        chk("rst_rsp", {6'b0, rsp_stat, rsp_data}, 32'h0);
        @(negedge clk); reset = 1'b1; #1;
        chk("ready_pre_edge", cmd_ready, 1'b0);
        tick();
        chk("ready_post_edge", cmd_ready, 1'b1);

        // Table: one command per vector with a scripted ATS completion.
        for (int v = 0; v < 6; v++) begin
            push(vecs[v].a, vecs[v].b);
            chk("req_early", ats_req, 1'b0);
            wait_req(k);
            chk("req_latency", k, 1);
            chk("issue_ctrlA", ats_ctrlA, vecs[v].a);
            chk("issue_ctrlB", ats_ctrlB, vecs[v].b);
            t = 0; t_resp = -1;
            if (vecs[v].d > 0) begin
                for (int i = 1; i <= vecs[v].d; i++) begin
                    step();
                    if (i == vecs[v].d) begin
                        ats_ready = 1'b1; ats_stat = vecs[v].st; ats_data = vecs[v].dat;
                    end
                end
                step();
                ats_ready = 1'b0;
            end
            while (t_resp < 0 && t < 40) step();
            chk("rsp_latency", t_resp, vecs[v].lat);
            chk("rsp_stat", rsp_stat, vecs[v].est);
            chk("rsp_data", rsp_data, vecs[v].edat);
            chk("ctrl_held", {ats_ctrlA, ats_ctrlB}, {vecs[v].a, vecs[v].b});
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk("rsp_cleared", rsp_valid, 1'b0);
        end

        // Fill: five back-to-back commands against a stalled ATS.
        qa.delete(); qb.delete();
        for (int i = 0; i < 5; i++) begin
            chk("fill_ready", cmd_ready, 1'b1);
            push(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        end
        chk("full_ready", cmd_ready, 1'b0);
        chk("full_busy", busy, 1'b1);
        cd = 1; n = 0; rsp_ready = 1'b1;
        while ((qa.size() < 5 || busy) && n < 200) begin
            tick(); n++;
            if (ats_req) begin cd = 2; ats_ready = 1'b0; end
            else if (cd > 0) begin
                cd--;
                ats_ready = (cd == 0);
                ats_stat = 2'b01; ats_data = 24'(n);
            end else ats_ready = 1'b0;
        end
        ats_ready = 1'b0; rsp_ready = 1'b0;
        chk("drain_bound", n < 200, 1'b1);
        chk("drain_count", qa.size(), 5);
        for (int i = 0; i < 5 && i < qa.size(); i++) begin
            chk("order_ctrlA", qa[i], 16'h1000 + 16'(i));
            chk("order_ctrlB", qb[i], 16'h2000 + 16'(i));
        end

        // Backpressure: response held 10 cycles with a command queued behind it.
        push(16'h7777, 16'h8888);
        wait_req(k);
        tick();
        ats_ready = 1'b1; ats_stat = 2'b10; ats_data = 24'hABCDEF;
        tick();
        ats_ready = 1'b0;
        chk("bp_valid", rsp_valid, 1'b1);
        push(16'h9999, 16'h4444);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_stat", rsp_stat, 2'b10);
            chk("hold_data", rsp_data, 24'hABCDEF);
            chk("hold_noreq", ats_req, 1'b0);
            tick();
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        wait_req(k);
        chk("bp_next_req", ats_req, 1'b1);
        chk("bp_next_ctrlA", ats_ctrlA, 16'h9999);
        tick();
        ats_ready = 1'b1; ats_stat = 2'b00; ats_data = 24'h1;
        tick();
        ats_ready = 1'b0;
        wait_rsp(k);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        chk("bp_idle", busy, 1'b0);

        // Reset while WAITing with two commands still queued.
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_ctrlA = 16'hA000 + 16'(i); cmd_ctrlB = 16'hB000 + 16'(i);
            tick();
            if (i == 1) chk("rst_seq_req", ats_req, 1'b1);
        end
        cmd_valid = 1'b0;
        chk("rst_seq_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst_flags", {ats_req, rsp_valid, busy, cmd_ready}, 4'b0000);
        chk("midrst_ctrl", {ats_ctrlA, ats_ctrlB}, 32'h0);
        chk("midrst_rsp", {6'b0, rsp_stat, rsp_data}, 32'h0);
        @(negedge clk); reset = 1'b1;
        qsz = qa.size(); seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rsp_valid || busy) seen++;
        end
        chk("post_rst_quiet", seen, 0);
        chk("post_rst_noreq", qa.size(), qsz);
        chk("post_rst_ready", cmd_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
